// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: FSM states,
// data-bit counts, latched frame configuration and the parity helper.
package uart_tx_ctrl_pkg;

    // Transmit FSM states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Number of data bits sent per frame in each character mode.
    localparam logic [3:0] DATA_BITS_7 = 4'd7;
    localparam logic [3:0] DATA_BITS_8 = 4'd8;

    // Frame format captured when a byte moves into the shift register,
    // so register-map changes mid-frame only affect the next frame.
    typedef struct packed {
        logic bits8;
        logic par_en;
        logic stop2;
        logic par_bit;
    } frame_cfg_t;

    // Parity over the bits actually transmitted; bit 7 is excluded in 7-bit mode.
    function automatic logic frame_parity(input logic [7:0] data,
                                          input logic       bits8,
                                          input logic       odd);
        logic [7:0] sent;
        sent = bits8 ? data : {1'b0, data[6:0]};
        return (^sent) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one-entry holding register feeding a shift
// register that is serialised onto txd, one bit per tx_baud_pulse.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       tx_baud_pulse,
    input  logic       tx_enable,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    input  logic       data_bits8,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       stop2,
    output logic       txd,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_ovf
);

    tx_state_t  state_reg;
    logic [7:0] shift_reg;
    logic [3:0] bit_cnt_reg;
    logic       stop_cnt_reg;
    frame_cfg_t cfg_reg;
    logic       txd_reg;
    logic       busy_reg;

    logic [7:0] hold_reg;
    logic       ready_reg;
    logic       ovf_reg;

    logic       hold_full;
    logic       last_stop;
    logic       load;
    logic       accept;
    logic [3:0] data_bits;

    // The holding register is full exactly when tx_ready is low.
    assign hold_full = ~ready_reg;

    // True while the final stop bit period of the current frame is running.
    assign last_stop = (state_reg == ST_STOP) && (~cfg_reg.stop2 || stop_cnt_reg);

    // Holding-to-shift transfer: only on a pulse, from IDLE or at the end of
    // the last stop bit, so consecutive frames join without an idle gap.
    assign load = tx_baud_pulse && hold_full && tx_enable &&
                  ((state_reg == ST_IDLE) || last_stop);

    // A write is taken only while the holding register is empty.
    assign accept = tx_write && ready_reg;

    assign data_bits = cfg_reg.bits8 ? DATA_BITS_8 : DATA_BITS_7;

    // Holding register, ready flag and overflow pulse.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            hold_reg  <= 8'h00;
            ready_reg <= 1'b1;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= tx_write && ~ready_reg;
            // accept needs an empty holder and load needs a full one, so
            // the two never coincide.
            if (accept) begin
                hold_reg  <= tx_data;
                ready_reg <= 1'b0;
            end else if (load) begin
                ready_reg <= 1'b1;
            end
        end
    end

    // Frame sequencer: every state change and txd update waits for a pulse.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 4'd0;
            stop_cnt_reg <= 1'b0;
            cfg_reg      <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
        end else if (tx_baud_pulse) begin
            if (load) begin
                shift_reg       <= hold_reg;
                cfg_reg.bits8   <= data_bits8;
                cfg_reg.par_en  <= parity_en;
                cfg_reg.stop2   <= stop2;
                cfg_reg.par_bit <= frame_parity(hold_reg, data_bits8, parity_odd);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        state_reg <= ST_START;
                        txd_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_START: begin
                    state_reg   <= ST_DATA;
                    txd_reg     <= shift_reg[0];
                    shift_reg   <= {1'b0, shift_reg[7:1]};
                    bit_cnt_reg <= 4'd1;
                end
                ST_DATA: begin
                    if (bit_cnt_reg == data_bits) begin
                        if (cfg_reg.par_en) begin
                            state_reg <= ST_PARITY;
                            txd_reg   <= cfg_reg.par_bit;
                        end else begin
                            state_reg    <= ST_STOP;
                            txd_reg      <= 1'b1;
                            stop_cnt_reg <= 1'b0;
                        end
                    end else begin
                        txd_reg     <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end
                ST_PARITY: begin
                    state_reg    <= ST_STOP;
                    txd_reg      <= 1'b1;
                    stop_cnt_reg <= 1'b0;
                end
                ST_STOP: begin
                    if (!last_stop) begin
                        stop_cnt_reg <= 1'b1;
                    end else if (load) begin
                        state_reg <= ST_START;
                        txd_reg   <= 1'b0;
                    end else begin
                        state_reg <= ST_IDLE;
                        txd_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    txd_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign txd      = txd_reg;
    assign tx_ready = ready_reg;
    assign tx_busy  = busy_reg;
    assign tx_ovf   = ovf_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed and random frames are
// compared bit by bit against frame images built from the frame rules.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_baud_pulse = 1'b0;
    logic       tx_enable;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       data_bits8;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
    logic       txd;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_count = 0;
    int pcnt = 0;
    time last_pulse_t = 0;

    logic [11:0] exp_bits[$];
    int          exp_len[$];

    uart_tx_ctrl dut (
        .PCLK          (clk),
        .PRESETN       (rst_n),
        .tx_baud_pulse (tx_baud_pulse),
        .tx_enable     (tx_enable),
        .tx_write      (tx_write),
        .tx_data       (tx_data),
        .data_bits8    (data_bits8),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .stop2         (stop2),
        .txd           (txd),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .tx_ovf        (tx_ovf)
    );

    always #5 clk = ~clk;

    // Bit-period strobe: one cycle in every sixteen, driven away from posedge.
    always @(negedge clk) begin
        pcnt = (pcnt == 15) ? 0 : pcnt + 1;
        tx_baud_pulse = (pcnt == 15);
    end

    // Remember when the last strobe was sampled, for start-bit alignment.
    always @(posedge clk) begin
        if (tx_baud_pulse) last_pulse_t = $time;
    end

    always @(negedge clk) begin
        if (tx_ovf === 1'b1) ovf_count++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_cfg(input logic b8, input logic pen, input logic podd, input logic s2);
        data_bits8 = b8;
        parity_en  = pen;
        parity_odd = podd;
        stop2      = s2;
    endtask

    // Expected line image of one frame under the current configuration.
    task automatic push_frame(input logic [7:0] d);
        logic [11:0] bits;
        int len;
        int ones;
        int nb;
        bits = '1;
        ones = 0;
        nb = data_bits8 ? 8 : 7;
        bits[0] = 1'b0;
        len = 1;
        for (int i = 0; i < nb; i++) begin
            bits[len] = d[i];
            if (d[i]) ones++;
            len++;
        end
        if (parity_en) begin
            bits[len] = ((ones % 2) == 1) ^ parity_odd;
            len++;
        end
        bits[len] = 1'b1;
        len++;
        if (stop2) begin
            bits[len] = 1'b1;
            len++;
        end
        exp_bits.push_back(bits);
        exp_len.push_back(len);
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic write_byte(input logic [7:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        @(negedge clk);
        tx_write = 1'b0;
    endtask

    task automatic wait_start(input int bound, input string tag);
        int w;
        w = 0;
        while (txd !== 1'b0 && w < bound) begin
            @(negedge clk);
            w++;
        end
        chk(tag, {31'd0, txd}, 32'd0);
    endtask

    // Check n queued frames; contiguous frames must follow with no gap,
    // every bit must hold for exactly sixteen cycles, and the line must be
    // idle with tx_busy low right after the final stop bit.
    task automatic check_frames(input int n, input int bound);
        int w;
        logic [11:0] b;
        int len;
        bit all_ok;
        w = 0;
        while (txd !== 1'b0 && w < bound) begin
            @(negedge clk);
            w++;
        end
        chk("start_seen", {31'd0, txd}, 32'd0);
        if (txd !== 1'b0) begin
            for (int f = 0; f < n; f++) begin
                void'(exp_bits.pop_front());
                void'(exp_len.pop_front());
            end
            return;
        end
        chk("start_align", 32'($time - last_pulse_t), 32'd5);
        for (int f = 0; f < n; f++) begin
            b = exp_bits.pop_front();
            len = exp_len.pop_front();
            chk($sformatf("busy_f%0d", f), {31'd0, tx_busy}, 32'd1);
            for (int k = 0; k < len; k++) begin
                all_ok = 1'b1;
                for (int c = 0; c < 16; c++) begin
                    if (txd !== b[k]) all_ok = 1'b0;
                    @(negedge clk);
                end
                chk($sformatf("frame%0d_bit%0d", f, k), {31'd0, all_ok}, 32'd1);
            end
        end
        chk("idle_txd", {31'd0, txd}, 32'd1);
        chk("idle_busy", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        int ovf_before;
        bit all_high;
        logic [7:0] d;
        logic [3:0] rc;

        rst_n     = 1'b0;
        tx_enable = 1'b1;
        tx_write  = 1'b0;
        tx_data   = 8'h00;
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_ovf", {31'd0, tx_ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1, 8E1, 8O1 with 0xA5 and 7E2 with 0xC1.
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        push_frame(8'hA5);
        write_byte(8'hA5);
        chk("wr_ready_low", {31'd0, tx_ready}, 32'd0);
        check_frames(1, 40);
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0);
        push_frame(8'hA5);
        write_byte(8'hA5);
        check_frames(1, 40);
        set_cfg(1'b1, 1'b1, 1'b1, 1'b0);
        push_frame(8'hA5);
        write_byte(8'hA5);
        check_frames(1, 40);
        set_cfg(1'b0, 1'b1, 1'b0, 1'b1);
        push_frame(8'hC1);
        write_byte(8'hC1);
        check_frames(1, 40);

        // Random bytes and formats.
        for (int r = 0; r < 6; r++) begin
            d  = 8'($urandom);
            rc = 4'($urandom);
            set_cfg(rc[0], rc[1], rc[2], rc[3]);
            push_frame(d);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            write_byte(d);
            check_frames(1, 40);
        end

        // Back-to-back: second byte written once tx_ready returns; its
        // format is changed while the first frame is on the line.
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        push_frame(8'h55);
        rc = 4'($urandom);
        set_cfg(rc[0], rc[1], rc[2], rc[3]);
        push_frame(8'h0F);
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        fork
            begin
                write_byte(8'h55);
                wait_start(40, "b2b_start");
                chk("ready_rise", {31'd0, tx_ready}, 32'd1);
                set_cfg(rc[0], rc[1], rc[2], rc[3]);
                write_byte(8'h0F);
            end
            check_frames(2, 40);
        join

        // Overflow: third write while the holder is full is dropped.
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        push_frame(8'h11);
        push_frame(8'h22);
        ovf_before = ovf_count;
        fork
            begin
                write_byte(8'h11);
                wait_start(40, "ovf_start");
                write_byte(8'h22);
                write_byte(8'h33);
                chk("ovf_pulse", {31'd0, tx_ovf}, 32'd1);
                @(negedge clk);
                chk("ovf_clear", {31'd0, tx_ovf}, 32'd0);
            end
            check_frames(2, 40);
        join
        chk("ovf_count", 32'(ovf_count - ovf_before), 32'd1);

        // Enable gating: byte waits in the holder until tx_enable rises.
        tx_enable = 1'b0;
        push_frame(8'h3C);
        write_byte(8'h3C);
        all_high = 1'b1;
        repeat (40) begin
            if (txd !== 1'b1) all_high = 1'b0;
            @(negedge clk);
        end
        chk("gate_txd_idle", {31'd0, all_high}, 32'd1);
        chk("gate_ready", {31'd0, tx_ready}, 32'd0);
        chk("gate_busy", {31'd0, tx_busy}, 32'd0);
        tx_enable = 1'b1;
        check_frames(1, 17);

        // Enable dropped mid-frame: frame completes, second byte is held.
        d = 8'($urandom);
        push_frame(d);
        push_frame(8'h96);
        fork
            begin
                write_byte(d);
                wait_start(40, "dis_start");
                write_byte(8'h96);
                repeat (20) @(negedge clk);
                tx_enable = 1'b0;
            end
            check_frames(1, 40);
        join
        all_high = 1'b1;
        repeat (40) begin
            if (txd !== 1'b1) all_high = 1'b0;
            @(negedge clk);
        end
        chk("dis_txd_idle", {31'd0, all_high}, 32'd1);
        chk("dis_hold_kept", {31'd0, tx_ready}, 32'd0);
        tx_enable = 1'b1;
        check_frames(1, 17);

        // Reset during DATA with the holder full: all outputs return at once.
        write_byte(8'hE7);
        wait_start(40, "rst_frame_start");
        write_byte(8'h5A);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        all_high = 1'b1;
        repeat (40) begin
            if (txd !== 1'b1) all_high = 1'b0;
            @(negedge clk);
        end
        chk("post_rst_idle", {31'd0, all_high}, 32'd1);
        chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);

        // Normal operation after reset.
        d  = 8'($urandom);
        rc = 4'($urandom);
        set_cfg(rc[0], rc[1], rc[2], rc[3]);
        push_frame(d);
        write_byte(d);
        check_frames(1, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
